// File: rtl/cpu_rst_clken_gen.sv
// Reset sequencer (staggered per-channel release) and clock-enable generator (run/divide/step/halt).
// Optional: define CLKEN_CYCLE_CNT_EN to add the 32-bit en_cycle_cnt pulse counter output.
module cpu_rst_clken_gen #(
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int STAGGER     = 2,
  parameter int DIV_W       = 8,
  parameter int STEP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  output logic [NUM_CH-1:0] ch_rst_out,
  output logic              ready,
  output logic              clk_en,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left
`ifdef CLKEN_CYCLE_CNT_EN
  ,
  output logic [31:0]       en_cycle_cnt
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {HOLD, RELEASE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              clk_en_q, clk_en_d;
  logic              busy_q, busy_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;

  // A software request behaves exactly like rst: everything returns to the start of HOLD.
  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      ch_rst_q  <= '1;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      steps_q   <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ch_rst_q  <= ch_rst_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
      steps_q   <= steps_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ch_rst_d = ch_rst_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d       = '0;
          ch_rst_d[0] = 1'b0;
          idx_d       = IDX_W'(1);
          state_d     = (NUM_CH == 1) ? ACTIVE : RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d           = '0;
          ch_rst_d[idx_q] = 1'b0;
          if (idx_q == LAST_CH) state_d = ACTIVE;
          else                  idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE:  ;
      default: state_d = HOLD;
    endcase
  end

  // Divide counter and step burst are held cleared whenever their mode is not selected,
  // which gives clear-on-entry and abort-on-exit for free.
  always_comb begin
    clk_en_d  = 1'b0;
    busy_d    = 1'b0;
    steps_d   = '0;
    div_cnt_d = '0;
    if (state_q == ACTIVE) begin
      case (mode)
        MODE_RUN: clk_en_d = 1'b1;
        MODE_DIV: begin
          if (div_cnt_q >= div) clk_en_d  = 1'b1;
          else                  div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        MODE_STEP: begin
          if (busy_q) begin
            clk_en_d = 1'b1;
            steps_d  = (steps_q != '0) ? steps_q - STEP_W'(1) : '0;
            busy_d   = (steps_d != '0);
          end else if (step_req) begin
            steps_d = (step_count == '0) ? STEP_W'(1) : step_count;
            busy_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_rst_out = ch_rst_q;
  assign ready      = (state_q == ACTIVE);
  assign clk_en     = clk_en_q;
  assign busy       = busy_q;
  assign steps_left = steps_q;

`ifdef CLKEN_CYCLE_CNT_EN
  logic [31:0] en_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) en_cnt_q <= '0;
    else if (clk_en_d)     en_cnt_q <= en_cnt_q + 32'd1;
  end
  assign en_cycle_cnt = en_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_rst_clken_gen.sv
// Directed self-checking bench for cpu_rst_clken_gen with default parameters.
module tb_cpu_rst_clken_gen;

  logic        clk = 1'b0;
  logic        rst, sw_rst_req, step_req;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic [15:0] step_count;
  logic [2:0]  ch_rst_out;
  logic        ready, clk_en, busy;
  logic [15:0] steps_left;
`ifdef CLKEN_CYCLE_CNT_EN
  logic [31:0] en_cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cpu_rst_clken_gen dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .mode       (mode),
    .div        (div),
    .step_req   (step_req),
    .step_count (step_count),
    .ch_rst_out (ch_rst_out),
    .ready      (ready),
    .clk_en     (clk_en),
    .busy       (busy),
    .steps_left (steps_left)
`ifdef CLKEN_CYCLE_CNT_EN
    ,
    .en_cycle_cnt (en_cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Release sequence after a reset source drops: edge e with rst=0 counted from 1.
  task automatic test_release_seq(input string tag);
    logic [2:0] exp_ch;
    logic       exp_rdy;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_ch  = (e < 5) ? 3'b111 : (e < 7) ? 3'b110 : (e < 9) ? 3'b100 : 3'b000;
      exp_rdy = (e >= 9);
      checks++;
      if (ch_rst_out !== exp_ch) begin
        errors++;
        $display("FAIL %s ch_rst_out edge %0d: got %b expected %b", tag, e, ch_rst_out, exp_ch);
      end
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s ready edge %0d: got %b expected %b", tag, e, ready, exp_rdy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sw_rst_req = 1'b0; step_req = 1'b0;
    mode = 2'b00; div = 8'd0; step_count = 16'd0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({ch_rst_out, ready, clk_en, busy, steps_left} !== {3'b111, 3'b000, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: got ch=%b rdy=%b en=%b busy=%b left=%0d expected ch=111 rdy=0 en=0 busy=0 left=0",
               ch_rst_out, ready, clk_en, busy, steps_left);
    end
`ifdef CLKEN_CYCLE_CNT_EN
    checks++;
    if (en_cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", en_cycle_cnt);
    end
`endif
    rst = 1'b0;
    test_release_seq("poweron");
  endtask

  task automatic test_run_halt;
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clk_en !== 1'b1) begin
        errors++;
        $display("FAIL run clk_en cycle %0d: got %b expected 1", i, clk_en);
      end
    end
    mode = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (clk_en !== 1'b0) begin
        errors++;
        $display("FAIL halt clk_en cycle %0d: got %b expected 0", i, clk_en);
      end
    end
  endtask

  task automatic test_divide;
    logic [9:0] pat;
    pat = 10'b0010001000; // bit i = expected clk_en on cycle i, div=3
    mode = 2'b01; div = 8'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (clk_en !== pat[i]) begin
        errors++;
        $display("FAIL div3 clk_en cycle %0d: got %b expected %b", i, clk_en, pat[i]);
      end
    end
    div = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clk_en !== 1'b1) begin
        errors++;
        $display("FAIL div0 clk_en cycle %0d: got %b expected 1", i, clk_en);
      end
    end
  endtask

  task automatic test_step;
    logic [2:0]  exp_en;
    logic [2:0]  exp_busy;
    logic [15:0] exp_left [0:4];
    int          pulses;
    mode = 2'b10; step_count = 16'd3;
    tick();
    checks++;
    if ({clk_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL step_idle: got en=%b busy=%b expected en=0 busy=0", clk_en, busy);
    end
    step_req = 1'b1;
    exp_en = 3'b0; exp_busy = 3'b0;
    exp_left[0] = 16'd3; exp_left[1] = 16'd2; exp_left[2] = 16'd1; exp_left[3] = 16'd0; exp_left[4] = 16'd0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      step_req = (i == 1);            // retrigger mid-burst must be ignored
      step_count = (i == 1) ? 16'd7 : 16'd3;
      if (clk_en === 1'b1) pulses++;
      checks++;
      if (clk_en !== (i >= 1 && i <= 3) || busy !== (i <= 2) || steps_left !== exp_left[i]) begin
        errors++;
        $display("FAIL step3 cycle %0d: got en=%b busy=%b left=%0d expected en=%b busy=%b left=%0d",
                 i, clk_en, busy, steps_left, (i >= 1 && i <= 3), (i <= 2), exp_left[i]);
      end
    end
    step_req = 1'b0;
    tick();
    if (clk_en === 1'b1) pulses++;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL step3_pulses: got %0d expected 3", pulses);
    end
    step_count = 16'd0; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++;
    if ({clk_en, busy, steps_left} !== {2'b01, 16'd1}) begin
      errors++;
      $display("FAIL step0_load: got en=%b busy=%b left=%0d expected en=0 busy=1 left=1", clk_en, busy, steps_left);
    end
    tick();
    checks++;
    if ({clk_en, busy, steps_left} !== {2'b10, 16'd0}) begin
      errors++;
      $display("FAIL step0_pulse: got en=%b busy=%b left=%0d expected en=1 busy=0 left=0", clk_en, busy, steps_left);
    end
    tick();
    checks++;
    if (clk_en !== 1'b0) begin
      errors++;
      $display("FAIL step0_after: got en=%b expected 0", clk_en);
    end
    // Leaving step mode mid-burst aborts it.
    step_count = 16'd5; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    mode = 2'b11;
    tick();
    checks++;
    if ({clk_en, busy, steps_left} !== {2'b00, 16'd0}) begin
      errors++;
      $display("FAIL step_abort: got en=%b busy=%b left=%0d expected en=0 busy=0 left=0", clk_en, busy, steps_left);
    end
  endtask

  task automatic test_sw_reset;
    mode = 2'b10; step_count = 16'd10; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    checks++;
    if ({clk_en, busy, steps_left} !== {2'b11, 16'd6}) begin
      errors++;
      $display("FAIL sw_pulse4: got en=%b busy=%b left=%0d expected en=1 busy=1 left=6", clk_en, busy, steps_left);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if ({ch_rst_out, ready, clk_en, busy, steps_left} !== {3'b111, 3'b000, 16'd0}) begin
      errors++;
      $display("FAIL sw_reset: got ch=%b rdy=%b en=%b busy=%b left=%0d expected ch=111 rdy=0 en=0 busy=0 left=0",
               ch_rst_out, ready, clk_en, busy, steps_left);
    end
`ifdef CLKEN_CYCLE_CNT_EN
    checks++;
    if (en_cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL sw_reset_cnt: got %0d expected 0", en_cycle_cnt);
    end
`endif
    test_release_seq("swrst");
  endtask

  task automatic test_rst_in_release;
    mode = 2'b00;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ch_rst_out !== 3'b110) begin
      errors++;
      $display("FAIL pre_rst ch_rst_out: got %b expected 110", ch_rst_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ch_rst_out, ready} !== 4'b1110) begin
      errors++;
      $display("FAIL rst_in_release: got ch=%b rdy=%b expected ch=111 rdy=0", ch_rst_out, ready);
    end
    test_release_seq("rst_release");
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_divide();
    test_step();
    test_sw_reset();
    test_rst_in_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
